fire7_squeeze_bias_relu: RTL and testbench
==========================================

// Module: fire7_squeeze_bias_relu
// PURPOSE
//  Post-accumulation stage for fire7 squeeze (64 output channels). Consumes one 32-bit
//  signed conv accumulator per channel, adds that channel's bias from the bias table,
//  applies ReLU, then round-shifts and narrows to the activation width. Output is a
//  valid/ready stream to the fire7 expand input buffer. 2-stage pipeline with backpressure.
// PARAMETERS
//  NUM_CH     64  output channels; bias table depth; channel counter modulus
//  ACC_W      32  accumulator and bias width (two's complement)
//  OUT_W      16  output activation width
//  FRAC_SHIFT 8   right shift applied after ReLU (fixed-point rescale), >=1
// PORTS
//  clk          in   1              clock, rising edge
//  rst          in   1              asynchronous reset, active-high
//  bias_mem     in   ACC_W x NUM_CH bias table, static after reset
//  sync_clr     in   1              synchronous flush: pipeline emptied, channel counter to 0
//  in_valid     in   1              accumulator word valid
//  in_ready     out  1              stage can accept
//  in_data      in   ACC_W          signed accumulator for the current channel
//  in_last      in   1              marks the final channel (NUM_CH-1) of a pixel
//  out_valid    out  1              result valid
//  out_ready    in   1              downstream accepts
//  out_data     out  OUT_W          unsigned post-ReLU activation
//  out_channel  out  $clog2(NUM_CH) channel index of out_data
//  out_last     out  1              out_channel == NUM_CH-1
//  channel_err  out  1              sticky: in_last disagreed with the channel counter
// BEHAVIOUR
//  - Reset: all valid flags 0, out_data/out_channel/out_last 0, channel counter 0,
//    channel_err 0. Reset mid-stream discards in-flight words; no partial output.
//  - Input handshake: transfer when in_valid && in_ready. in_ready = !s1_valid ||
//    s2_advance (s2_advance = !out_valid || out_ready). Data held while stalled.
//  - Channel counter ch increments on each input transfer and wraps NUM_CH-1 -> 0.
//    A word's channel is ch at transfer time. in_last is not used to reset ch.
//  - channel_err set when a transfer has in_last != (ch == NUM_CH-1). Cleared only by
//    rst or sync_clr.
//  - S1 (1 cycle): sum = sext33(in_data) + sext33(bias_mem[ch]); channel index carried.
//  - S2 (1 cycle): r = (sum < 0) ? 0 : sum; q = (r + 2**(FRAC_SHIFT-1)) >> FRAC_SHIFT.
//    Computed in ACC_W+2 bits; no intermediate overflow.
//  - Latency: 2 cycles from input transfer to out_valid with no stall. Throughput: 1/clk.
//  - Stall: out_valid && !out_ready holds S2 and out_* stable. S1 fills, then in_ready
//    drops. No word is dropped or duplicated.
//  - Simultaneous accept and emit in one cycle is legal at full rate.
//  - sync_clr has priority over a same-cycle transfer. That word is discarded, ch = 0,
//    and out_valid = 0 next cycle.
// CONFIGURATION
//  FIRE7_SQUEEZE_SAT_EN defined: q > 2**OUT_W-1 saturates to 2**OUT_W-1 (0xFFFF).
//  Not defined: out_data = q[OUT_W-1:0] (wraps). All other behaviour is identical.
// TESTING
//  1. Bench drives bias_mem[0]=-187, bias_mem[37]=1357, rest 0.
//     in_data=1000 on ch0 -> out_data=3, out_channel=0, 2 cycles later.
//  2. in_data=-5000 on ch0 -> sum -5187, ReLU -> out_data=0.
//     in_data=0 on ch37 -> out_data=5.
//  3. 64 back-to-back words with in_last on the 64th and out_ready=1 -> 64 outputs on
//     consecutive cycles, out_last only on ch63, ch wraps to 0, channel_err=0.
//  4. out_ready=0 for 5 cycles mid-burst -> in_ready drops after 2 buffered words,
//     out_* stable. Output order and count are unchanged vs test 3.
//  5. in_data=0x7FFFFFFF on ch1 (bias 0).
//     With FIRE7_SQUEEZE_SAT_EN -> out_data=0xFFFF. Without -> out_data=0x0000.
//  6. in_last on ch10 -> channel_err=1, held. rst asserted mid-burst -> out_valid=0
//     immediately; after release, the next word is ch0.

Source files
------------

// File: rtl/fire7_squeeze_bias_relu.sv
// fire7 squeeze post-accumulation: per-channel bias add, ReLU, rounded rescale, narrow.
// Optional output saturation is enabled with `define FIRE7_SQUEEZE_SAT_EN.
module fire7_squeeze_bias_relu #(
    parameter  int unsigned NUM_CH     = 64,
    parameter  int unsigned ACC_W      = 32,
    parameter  int unsigned OUT_W      = 16,
    parameter  int unsigned FRAC_SHIFT = 8,
    localparam int unsigned CH_W       = $clog2(NUM_CH)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_CH-1:0][ACC_W-1:0]     bias_mem,
    input  logic                             sync_clr,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [ACC_W-1:0]                 in_data,
    input  logic                             in_last,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [OUT_W-1:0]                 out_data,
    output logic [CH_W-1:0]                  out_channel,
    output logic                             out_last,
    output logic                             channel_err
);

    localparam logic [ACC_W+1:0] RND = (ACC_W+2)'(1) << (FRAC_SHIFT - 1);

    logic [CH_W-1:0]  r_ch;
    logic             r_s1_valid;
    logic [ACC_W:0]   r_s1_sum;
    logic [CH_W-1:0]  r_s1_ch;

    logic             w_s2_adv;
    logic             w_in_xfer;
    logic             w_ch_last;
    logic [ACC_W-1:0] w_bias;
    logic [ACC_W:0]   w_sum;
    logic [ACC_W+1:0] w_relu;
    logic [ACC_W+1:0] w_q;
    logic [OUT_W-1:0] w_out;

    assign w_s2_adv  = !out_valid || out_ready;
    assign in_ready  = !r_s1_valid || w_s2_adv;
    assign w_in_xfer = in_valid && in_ready;
    assign w_ch_last = (r_ch == CH_W'(NUM_CH - 1));

    assign w_bias = bias_mem[r_ch];
    assign w_sum  = {in_data[ACC_W-1], in_data} + {w_bias[ACC_W-1], w_bias};

    // Sign bit of the 33-bit sum selects ReLU; two spare bits keep the rounding add exact.
    assign w_relu = r_s1_sum[ACC_W] ? '0 : {1'b0, r_s1_sum};
    assign w_q    = (w_relu + RND) >> FRAC_SHIFT;

`ifdef FIRE7_SQUEEZE_SAT_EN
    assign w_out = (|w_q[ACC_W+1:OUT_W]) ? '1 : w_q[OUT_W-1:0];
`else
    logic w_unused_q_hi;
    assign w_unused_q_hi = ^w_q[ACC_W+1:OUT_W];
    assign w_out         = w_q[OUT_W-1:0];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ch        <= '0;
            r_s1_valid  <= 1'b0;
            r_s1_sum    <= '0;
            r_s1_ch     <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_channel <= '0;
            out_last    <= 1'b0;
            channel_err <= 1'b0;
        end else if (sync_clr) begin
            r_ch        <= '0;
            r_s1_valid  <= 1'b0;
            out_valid   <= 1'b0;
            channel_err <= 1'b0;
        end else begin
            if (w_in_xfer) begin
                r_ch <= w_ch_last ? '0 : r_ch + 1'b1;
                if (in_last != w_ch_last) begin
                    channel_err <= 1'b1;
                end
            end
            // S2 only moves when its current word is taken (or absent).
            if (w_s2_adv) begin
                out_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    out_data    <= w_out;
                    out_channel <= r_s1_ch;
                    out_last    <= (r_s1_ch == CH_W'(NUM_CH - 1));
                end
            end
            if (in_ready) begin
                r_s1_valid <= in_valid;
                if (in_valid) begin
                    r_s1_sum <= w_sum;
                    r_s1_ch  <= r_ch;
                end
            end
        end
    end

endmodule

// File: tb/tb_fire7_squeeze_bias_relu.sv
// Randomized bench for fire7_squeeze_bias_relu with a queue-based arithmetic reference model.
module tb_fire7_squeeze_bias_relu;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [63:0][31:0]    bias_mem;
    logic                 sync_clr = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [31:0]          in_data = '0;
    logic                 in_last = 1'b0;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic [15:0]          out_data;
    logic [5:0]           out_channel;
    logic                 out_last;
    logic                 channel_err;

    fire7_squeeze_bias_relu #(
        .NUM_CH(64), .ACC_W(32), .OUT_W(16), .FRAC_SHIFT(8)
    ) dut (
        .clk(clk), .rst(rst), .bias_mem(bias_mem), .sync_clr(sync_clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_channel(out_channel), .out_last(out_last), .channel_err(channel_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] d;
        int          c;
        logic        l;
    } exp_t;

    int          n_checks = 0;
    int          n_errors = 0;
    exp_t        exp_q[$];
    exp_t        e;
    int          m_ch = 0;
    bit          m_err = 0;
    int          drv_ch = 0;
    logic [15:0] out_by_ch [64];
    int          last_out_ch = -1;
    int          run_len = 0;
    int          max_run = 0;
    bit          prev_hs = 0;
    bit          prev_stall = 0;
    bit          prev_clr = 0;
    logic [15:0] prev_d;
    logic [5:0]  prev_c;
    logic        prev_l;

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    function automatic logic [15:0] ref_q(input logic [31:0] d, input logic [31:0] b);
        longint s;
        s = longint'($signed(d)) + longint'($signed(b));
        if (s < 0) s = 0;
        s = (s + 128) / 256;
`ifdef FIRE7_SQUEEZE_SAT_EN
        if (s > 65535) s = 65535;
`endif
        return s[15:0];
    endfunction

    // Scoreboard: compare outputs first, then account for the input side of the same edge.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            m_ch = 0; m_err = 0;
            prev_stall = 0; prev_hs = 0; prev_clr = 0; run_len = 0;
        end else begin
            if (prev_stall && !prev_clr) begin
                check_eq("stall_valid", out_valid, 1);
                check_eq("stall_data", out_data, prev_d);
                check_eq("stall_chan", out_channel, prev_c);
                check_eq("stall_last", out_last, prev_l);
            end
            if (out_valid && out_ready) begin
                run_len = prev_hs ? run_len + 1 : 1;
                if (run_len > max_run) max_run = run_len;
                if (exp_q.size() == 0) begin
                    check_eq("out_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("out_data", out_data, e.d);
                    check_eq("out_channel", out_channel, e.c);
                    check_eq("out_last", out_last, e.l);
                end
                out_by_ch[out_channel] = out_data;
                last_out_ch = out_channel;
            end
            check_eq("channel_err", channel_err, m_err);
            if (sync_clr) begin
                exp_q.delete();
                m_ch = 0; m_err = 0;
            end else if (in_valid && in_ready) begin
                e.d = ref_q(in_data, bias_mem[m_ch]);
                e.c = m_ch;
                e.l = (m_ch == 63);
                exp_q.push_back(e);
                if (in_last != (m_ch == 63)) m_err = 1;
                m_ch = (m_ch + 1) % 64;
            end
            prev_hs    = out_valid && out_ready;
            prev_stall = out_valid && !out_ready;
            prev_clr   = sync_clr;
            prev_d = out_data; prev_c = out_channel; prev_l = out_last;
        end
    end

    task automatic send_word(input logic [31:0] d, input bit bad_last);
        bit got = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = bad_last ? 1'b1 : (drv_ch == 63);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (in_ready) begin got = 1; break; end
        end
        @(posedge clk); #1;
        if (!got) check_eq("in_ready_timeout", 0, 1);
        drv_ch = (drv_ch + 1) % 64;
    endtask

    function automatic logic [31:0] rand_word();
        if ($urandom_range(0, 3) == 0) return $urandom;
        return 32'($urandom_range(0, 200000)) - 32'd100000;
    endfunction

    task automatic burst(input int n);
        for (int i = 0; i < n; i++) send_word(rand_word(), 0);
        in_valid = 1'b0;
    endtask

    task automatic do_clr();
        in_valid = 1'b0;
        sync_clr = 1'b1;
        @(posedge clk); #1;
        sync_clr = 1'b0;
        drv_ch = 0;
    endtask

    task automatic drain();
        int k = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && k < 100) begin
            @(posedge clk);
            k++;
        end
        repeat (2) @(posedge clk);
        #1;
        check_eq("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) bias_mem[i] = '0;
        bias_mem[0]  = -32'sd187;
        bias_mem[37] = 32'd1357;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_data", out_data, 0);
        check_eq("rst_out_channel", out_channel, 0);
        check_eq("rst_out_last", out_last, 0);
        check_eq("rst_channel_err", channel_err, 0);
        check_eq("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;
        rst = 1'b0;

        // Test 1: single word, latency 2
        in_valid = 1'b1; in_data = 32'd1000; in_last = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_eq("t1_not_yet_valid", out_valid, 0);
        @(posedge clk); #1;
        check_eq("t1_valid", out_valid, 1);
        check_eq("t1_data", out_data, 3);
        check_eq("t1_channel", out_channel, 0);
        drain();

        // Test 2: ReLU clamp on ch0, bias-only value on ch37
        do_clr();
        send_word(-32'sd5000, 0);
        for (int i = 1; i < 37; i++) send_word(rand_word(), 0);
        send_word(32'd0, 0);
        drain();
        check_eq("t2_ch0_relu", out_by_ch[0], 0);
        check_eq("t2_ch37_bias", out_by_ch[37], 5);

        // Test 3: full pixel at full rate
        do_clr();
        max_run = 0;
        burst(64);
        drain();
        check_eq("t3_consecutive", max_run, 64);
        check_eq("t3_last_chan", last_out_ch, 63);
        check_eq("t3_err", channel_err, 0);
        send_word(32'd1000, 0);
        in_valid = 1'b0;
        drain();
        check_eq("t3_wrap_chan", last_out_ch, 0);

        // Test 4: downstream stall mid-burst
        do_clr();
        fork
            burst(64);
            begin
                repeat (20) @(posedge clk);
                #1;
                out_ready = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    if (i >= 1) begin
                        check_eq("t4_in_ready_low", in_ready, 0);
                        check_eq("t4_out_valid_held", out_valid, 1);
                    end
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();
        check_eq("t4_last_chan", last_out_ch, 63);

        // Test 5: large positive accumulator
        do_clr();
        send_word(32'd0, 0);
        send_word(32'h7FFF_FFFF, 0);
        drain();
`ifdef FIRE7_SQUEEZE_SAT_EN
        check_eq("t5_ch1_big", out_by_ch[1], 16'hFFFF);
`else
        check_eq("t5_ch1_big", out_by_ch[1], 16'h0000);
`endif

        // Random traffic with random backpressure
        do_clr();
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    send_word(rand_word(), 0);
                    if ($urandom_range(0, 3) == 0) begin
                        in_valid = 1'b0;
                        repeat ($urandom_range(1, 3)) @(posedge clk);
                        #1;
                    end
                end
                in_valid = 1'b0;
            end
            begin
                repeat (400) begin
                    out_ready = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Test 6: misplaced in_last, then reset mid-burst
        do_clr();
        for (int i = 0; i < 10; i++) send_word(rand_word(), 0);
        send_word(rand_word(), 1);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("t6_err_sticky", channel_err, 1);
        for (int i = 0; i < 5; i++) send_word(rand_word(), 0);
        rst = 1'b1;
        #1;
        check_eq("t6_rst_out_valid", out_valid, 0);
        check_eq("t6_rst_err", channel_err, 0);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        drv_ch = 0;
        send_word(32'd1000, 0);
        in_valid = 1'b0;
        drain();
        check_eq("t6_after_rst_chan", last_out_ch, 0);
        check_eq("t6_after_rst_data", out_by_ch[0], 3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete, expected completion");
        $fatal(1, "timeout");
    end

endmodule
